// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM fade controller.
//   fade_state_t : controller FSM states (IDLE, ARM, RAMP)
//   WIDTH_DEF    : default duty / max_value width
//   STEP_W_DEF   : default width of the step-period count
package pwm_ctrl_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RAMP = 2'd2
  } fade_state_t;

endpackage

// File: rtl/period_tick_counter.sv
// Counts period_end pulses up to a programmable terminal value and emits a
// one-cycle tick on the pulse that reaches it, then restarts from zero.
//   clk        : clock
//   rst        : synchronous active-high reset
//   clear      : hold the count at zero and suppress tick
//   period_end : pulse to be counted
//   terminal   : pulses per tick (0 behaves as 1)
//   tick       : high in the cycle of the terminal pulse
module period_tick_counter
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              period_end,
  input  logic [STEP_W-1:0] terminal,
  output logic              tick
);

  logic [STEP_W-1:0] count;
  logic [STEP_W-1:0] term_eff;
  logic [STEP_W:0]   count_inc;

  always_comb begin
    term_eff  = (terminal == '0) ? STEP_W'(1) : terminal;
    // One extra bit so the compare cannot wrap at the top of the range.
    count_inc = {1'b0, count} + (STEP_W + 1)'(1);
    tick      = period_end && !clear && (count_inc >= {1'b0, term_eff});
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (period_end) begin
      count <= tick ? '0 : count_inc[STEP_W-1:0];
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade controller for a pwm_module: accepts a fade command (target duty,
// max_value, periods per step) and walks the registered duty toward the
// target one LSB at a time, updating only on PWM period boundaries.
//   clk, rst        : clock, synchronous active-high reset
//   cmd_valid/ready : command handshake (ready only in IDLE)
//   cmd_target      : final duty value
//   cmd_max         : max_value to apply
//   cmd_step        : PWM periods per 1-LSB duty step (0 behaves as 1)
//   cmd_abort       : stop the fade, holding current outputs
//   period_end      : one-cycle pulse when the PWM counter wraps
//   duty_out        : registered duty to the PWM
//   max_out         : registered max_value to the PWM
//   busy            : not IDLE
//   done            : one-cycle pulse when the duty reaches the target
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [WIDTH-1:0]  cmd_max,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              cmd_abort,
  input  logic              period_end,
  output logic [WIDTH-1:0]  duty_out,
  output logic [WIDTH-1:0]  max_out,
  output logic              busy,
  output logic              done
);

  fade_state_t       state, state_nxt;
  logic [WIDTH-1:0]  lat_target, lat_target_nxt;
  logic [WIDTH-1:0]  lat_max, lat_max_nxt;
  logic [STEP_W-1:0] lat_step, lat_step_nxt;
  logic [WIDTH-1:0]  duty_nxt, max_nxt;
  logic              done_nxt;
  logic              cnt_clear;
  logic              tick;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // The counter only runs in RAMP, so it starts from zero on entry; an
  // abort clears it and masks the tick so abort wins over period_end.
  assign cnt_clear = (state != RAMP) || cmd_abort;

  period_tick_counter #(
    .STEP_W (STEP_W)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .period_end (period_end),
    .terminal   (lat_step),
    .tick       (tick)
  );

  always_comb begin
    state_nxt      = state;
    lat_target_nxt = lat_target;
    lat_max_nxt    = lat_max;
    lat_step_nxt   = lat_step;
    duty_nxt       = duty_out;
    max_nxt        = max_out;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        // period_end and cmd_abort are ignored here; a command accepted on a
        // period_end cycle is applied on the next period_end from ARM.
        if (cmd_valid) begin
          lat_target_nxt = cmd_target;
          lat_max_nxt    = cmd_max;
          lat_step_nxt   = cmd_step;
          state_nxt      = ARM;
        end
      end

      ARM: begin
        if (cmd_abort) begin
          state_nxt = IDLE;
        end else if (period_end) begin
          max_nxt        = lat_max;
          lat_target_nxt = (lat_target > lat_max) ? lat_max : lat_target;
          duty_nxt       = (duty_out > lat_max) ? lat_max : duty_out;
          if (duty_nxt == lat_target_nxt) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RAMP;
          end
        end
      end

      RAMP: begin
        if (cmd_abort) begin
          state_nxt = IDLE;
        end else if (tick) begin
          // Target and duty are both within 0..max_out after ARM, so moving
          // strictly toward the target can never wrap.
          if (duty_out < lat_target) begin
            duty_nxt = duty_out + WIDTH'(1);
          end else if (duty_out > lat_target) begin
            duty_nxt = duty_out - WIDTH'(1);
          end
          if (duty_nxt == lat_target) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_target <= '0;
      lat_max    <= '0;
      lat_step   <= '0;
      duty_out   <= '0;
      max_out    <= '1;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_target <= lat_target_nxt;
      lat_max    <= lat_max_nxt;
      lat_step   <= lat_step_nxt;
      duty_out   <= duty_nxt;
      max_out    <= max_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl. The stimulus process pushes every
// expected output event (duty/max change or done pulse) together with the
// number of period_end pulses since the command was accepted; the monitor
// pops one entry per observed event.
module tb_pwm_fade_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_target;
  logic [W-1:0]  cmd_max;
  logic [SW-1:0] cmd_step;
  logic          cmd_abort;
  logic          period_end;
  logic [W-1:0]  duty_out;
  logic [W-1:0]  max_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(
    .WIDTH  (W),
    .STEP_W (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_max    (cmd_max),
    .cmd_step   (cmd_step),
    .cmd_abort  (cmd_abort),
    .period_end (period_end),
    .duty_out   (duty_out),
    .max_out    (max_out),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [7:0]  duty;
    logic [7:0]  maxv;
    logic        dn;
    logic [15:0] pcnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void push_ev(input int d, input int m, input bit dn, input int p);
    ev_t e;
    e.duty = 8'(d);
    e.maxv = 8'(m);
    e.dn   = dn;
    e.pcnt = 16'(p);
    exp_q.push_back(e);
  endfunction

  // Full ramp: pulse 1 is the ARM pulse, then one LSB every stp pulses.
  function automatic void push_ramp(input int start, input int tgt, input int stp, input int m);
    int d;
    int p;
    d = start;
    p = 1;
    while (d != tgt) begin
      d = (tgt > d) ? d + 1 : d - 1;
      p = p + stp;
      push_ev(d, m, d == tgt, p);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    period_end = 1'b1;
    step_cyc();
    period_end = 1'b0;
    repeat (3) step_cyc();
  endtask

  task automatic send(input int t, input int m, input int s, input bit with_pe);
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_target = 8'(t);
    cmd_max    = 8'(m);
    cmd_step   = 8'(s);
    period_end = with_pe;
    step_cyc();
    cmd_valid  = 1'b0;
    period_end = 1'b0;
  endtask

  // Monitor
  logic [W-1:0] prev_duty;
  logic [W-1:0] prev_max;
  bit           rst_pend = 1'b1;
  int           pcnt = 0;
  ev_t          mon_e;

  always @(negedge clk) begin
    if (!rst_pend && (done || duty_out != prev_duty || max_out != prev_max)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got duty=%0d max=%0d done=%0d pe=%0d, required no event",
                 duty_out, max_out, done, pcnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (duty_out !== mon_e.duty || max_out !== mon_e.maxv ||
            done !== mon_e.dn || 16'(pcnt) !== mon_e.pcnt) begin
          errors++;
          $display("FAIL event: got duty=%0d max=%0d done=%0d pe=%0d, required duty=%0d max=%0d done=%0d pe=%0d",
                   duty_out, max_out, done, pcnt,
                   mon_e.duty, mon_e.maxv, mon_e.dn, mon_e.pcnt);
        end
      end
    end
    prev_duty = duty_out;
    prev_max  = max_out;
    if (rst) pcnt = 0;
    else if (cmd_valid && cmd_ready) pcnt = 0;
    else if (period_end) pcnt++;
    rst_pend = rst;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_max    = '0;
    cmd_step   = '0;
    cmd_abort  = 1'b0;
    period_end = 1'b0;
    repeat (3) step_cyc();
    chk("rst_duty", 32'(duty_out), 32'd0);
    chk("rst_max",  32'(max_out),  32'd255);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    step_cyc();
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Rise 0 -> 10, one LSB per period after ARM
    push_ramp(0, 10, 1, 255);
    send(10, 255, 1, 1'b0);
    chk("t1_busy_armed", {31'd0, busy}, 32'd1);
    repeat (11) pulse();
    chk("t1_duty", 32'(duty_out), 32'd10);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Fall 10 -> 2, step 3; accepted on a period_end cycle
    push_ramp(10, 2, 3, 255);
    send(2, 255, 3, 1'b1);
    repeat (25) pulse();
    chk("t2_duty", 32'(duty_out), 32'd2);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // Rise 2 -> 200 with step 0 (acts as 1)
    push_ramp(2, 200, 1, 255);
    send(200, 255, 0, 1'b0);
    repeat (199) pulse();
    chk("t3_duty", 32'(duty_out), 32'd200);

    // New max below duty and target: clamp, immediate done
    push_ev(100, 100, 1'b1, 1);
    send(150, 100, 1, 1'b0);
    pulse();
    chk("t3b_duty", 32'(duty_out), 32'd100);
    chk("t3b_max",  32'(max_out),  32'd100);
    chk("t3b_idle", {31'd0, busy}, 32'd0);

    // Fall from 100 toward 0 with max back at 255, abort at duty 5
    push_ev(100, 255, 1'b0, 1);
    for (int k = 1; k <= 95; k++) push_ev(100 - k, 255, 1'b0, 1 + k);
    send(0, 255, 1, 1'b0);
    repeat (96) pulse();
    chk("t4_mid_duty", 32'(duty_out), 32'd5);
    chk("t4_mid_busy", {31'd0, busy}, 32'd1);
    cmd_abort  = 1'b1;
    period_end = 1'b1;
    step_cyc();
    cmd_abort  = 1'b0;
    period_end = 1'b0;
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_duty",  32'(duty_out), 32'd5);
    chk("abort_done",  {31'd0, done}, 32'd0);
    repeat (2) pulse();
    chk("idle_pe_duty", 32'(duty_out), 32'd5);
    chk("idle_pe_max",  32'(max_out),  32'd255);

    // cmd_valid held through a fade (abort in IDLE on accept cycle ignored)
    push_ramp(5, 8, 1, 255);
    push_ramp(8, 3, 1, 255);
    cmd_valid  = 1'b1;
    cmd_target = 8'd8;
    cmd_max    = 8'd255;
    cmd_step   = 8'd1;
    cmd_abort  = 1'b1;
    step_cyc();
    cmd_abort  = 1'b0;
    cmd_target = 8'd3;
    chk("t5_busy", {31'd0, busy}, 32'd1);
    repeat (4) pulse();
    cmd_valid = 1'b0;
    chk("t5_second_busy", {31'd0, busy}, 32'd1);
    repeat (6) pulse();
    chk("t5_duty", 32'(duty_out), 32'd3);
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // Reset mid-RAMP
    push_ev(4, 255, 1'b0, 2);
    push_ev(5, 255, 1'b0, 3);
    send(50, 255, 1, 1'b0);
    repeat (3) pulse();
    chk("t6_mid_duty", 32'(duty_out), 32'd5);
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    chk("t6_rst_duty", 32'(duty_out), 32'd0);
    chk("t6_rst_max",  32'(max_out),  32'd255);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    step_cyc();
    chk("t6_post_done",  {31'd0, done}, 32'd0);
    chk("t6_post_ready", {31'd0, cmd_ready}, 32'd1);

    repeat (2) step_cyc();
    chk("events_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the PWM duty and max_value width.
REQ-002 SHALL have parameter STEP_W, default 8, giving the width of the step-period count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  fade command offered.
REQ-006 cmd_ready  output  1  controller accepts a command; high only in IDLE.
REQ-007 cmd_target  input  WIDTH  final duty value.
REQ-008 cmd_max  input  WIDTH  PWM max_value to apply.
REQ-009 cmd_step  input  STEP_W  PWM periods per 1-LSB duty step.
REQ-010 cmd_abort  input  1  stop the fade immediately.
REQ-011 period_end  input  1  one-cycle pulse from the PWM when its counter wraps.
REQ-012 duty_out  output  WIDTH  registered duty to the pwm_module duty input.
REQ-013 max_out  output  WIDTH  registered max_value to the pwm_module.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when the fade completes.

Function
REQ-016 SHALL implement an FSM with states IDLE, ARM, RAMP.
REQ-017 IDLE: a command is accepted when cmd_valid && cmd_ready; target, max and step are latched; next state ARM.
REQ-018 ARM: on the first period_end, max_out <= latched max and the latched target is clamped to min(target, max).
- In the same cycle, duty_out <= min(duty_out, new max).
- If the clamped duty equals the clamped target: done pulses and next state IDLE; otherwise next state RAMP.
REQ-019 RAMP: a step counter increments on each period_end. When the count reaches the latched step (a step of 0 is treated as 1), duty_out moves 1 LSB toward the target and the counter clears.
REQ-020 duty_out and max_out SHALL change only in cycles where period_end is high (glitch-free updates).
REQ-021 When duty_out reaches the target, done SHALL assert in the same registered cycle that duty_out takes the target value; next state IDLE.
REQ-022 Duty arithmetic SHALL saturate within 0..max_out and never wrap.
REQ-023 cmd_abort in ARM or RAMP: next state IDLE; duty_out and max_out hold; no done pulse. Abort wins over a simultaneous period_end.
REQ-024 cmd_abort in IDLE SHALL be ignored.
REQ-025 cmd_valid while busy SHALL be ignored; the command is not latched.
REQ-026 A period_end in IDLE SHALL have no effect.
REQ-027 A command accepted in the same cycle as a period_end SHALL wait for the next period_end to apply (no same-cycle apply).

Reset
REQ-028 While rst is high at a clock edge: state IDLE, duty_out 0, max_out all-ones, step counter 0, done 0, busy 0.
REQ-029 cmd_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-030 Reset mid-fade SHALL discard the latched command and produce no done pulse.

Structure
REQ-031 Package pwm_ctrl_pkg SHALL hold the FSM state enum and the default WIDTH and STEP_W constants.
REQ-032 The step counter SHALL be a sub-module, period_tick_counter: it counts period_end pulses up to a programmable terminal value and emits a one-cycle tick.
REQ-033 Total RTL SHALL be within 120-400 lines.

Verification
REQ-034 Reset, then target=10, max=255, step=1, period_end every 4 cycles -> duty_out rises 0..10 one LSB per period_end after ARM; done pulses once with duty_out=10.
REQ-035 From duty=10: target=2, step=3 -> duty_out decrements once every 3 period_end pulses; done pulses on reaching 2.
REQ-036 From duty=200: max=100, target=150 -> at the ARM period_end, max_out=100 and duty_out=100 together; immediate done; no ramp.
REQ-037 cmd_abort coincident with period_end mid-ramp (duty=5) -> duty_out stays 5; no done; cmd_ready=1 the next cycle.
REQ-038 cmd_valid held high while busy -> exactly one command accepted per fade; the second accepted only after done.
REQ-039 rst asserted mid-RAMP -> duty_out=0, max_out=255, busy=0, and no done pulse on the following edge.
